// File: rtl/matrix_stream_reader.sv
// Read-side sequencer for the multi-matrix store: queries one matrix (or every matrix of a
// scale), snapshots it locally and streams it row-major over a valid/ready interface.
module matrix_stream_reader #(
  parameter int DATA_WIDTH          = 8,
  parameter int MAX_SIZE            = 5,
  parameter int MAX_MATRIX_PER_SIZE = 4,
  parameter int SEL_IDX_W           = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [2:0]                             cmd_row,
  input  logic [2:0]                             cmd_col,
  input  logic [SEL_IDX_W-1:0]                   cmd_idx,
  input  logic                                   cmd_all,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [2:0]                             req_scale_row,
  output logic [2:0]                             req_scale_col,
  output logic [SEL_IDX_W-1:0]                   req_idx,
  input  logic                                   matrix_valid,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] matrix_data_flat,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [2:0]                             out_r,
  output logic [2:0]                             out_c,
  output logic                                   out_eol,
  output logic                                   out_eom,
  output logic                                   out_last,
  output logic [SEL_IDX_W-1:0]                   out_mat_idx
);

  localparam int NSLOT  = MAX_SIZE * MAX_SIZE;
  localparam int SLOT_W = $clog2(NSLOT);
  localparam logic [2:0]           MAX_DIM  = 3'(MAX_SIZE);
  localparam logic [SEL_IDX_W-1:0] LAST_IDX = SEL_IDX_W'(MAX_MATRIX_PER_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, STREAM, NEXT, FINISH} state_t;

  state_t                state;
  logic [2:0]            rows, cols;
  logic                  all_mode;
  logic                  streamed_any;
  logic [DATA_WIDTH-1:0] buffer [NSLOT];

  logic       cmd_bad, last_idx_hit, hs;
  logic       at_eol, at_eom;
  logic [2:0] nxt_r, nxt_c;
  logic       nxt_eol, nxt_eom, nxt_last;
  logic       load_eol, load_eom, load_last;

  function automatic logic [SLOT_W-1:0] slot_of(input logic [2:0] r, input logic [2:0] c);
    int unsigned s;
    s = r * MAX_SIZE + c;
    return SLOT_W'(s);
  endfunction

  // Flags are precomputed for the element that becomes current after a handshake,
  // so every out_* field is a plain register.
  always_comb begin
    cmd_bad      = (cmd_row == 3'd0) || (cmd_row > MAX_DIM) ||
                   (cmd_col == 3'd0) || (cmd_col > MAX_DIM);
    last_idx_hit = (req_idx == LAST_IDX);
    hs           = out_valid && out_ready;
    at_eol       = (out_c == cols - 3'd1);
    at_eom       = at_eol && (out_r == rows - 3'd1);
    nxt_c        = at_eol ? 3'd0 : out_c + 3'd1;
    nxt_r        = at_eol ? out_r + 3'd1 : out_r;
    nxt_eol      = (nxt_c == cols - 3'd1);
    nxt_eom      = nxt_eol && (nxt_r == rows - 3'd1);
    nxt_last     = nxt_eom && (!all_mode || last_idx_hit);
    load_eol     = (cols == 3'd1);
    load_eom     = load_eol && (rows == 3'd1);
    load_last    = load_eom && (!all_mode || last_idx_hit);
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && matrix_valid) begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        buffer[SLOT_W'(k)] <= matrix_data_flat[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rows          <= '0;
      cols          <= '0;
      all_mode      <= 1'b0;
      streamed_any  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      req_scale_row <= '0;
      req_scale_col <= '0;
      req_idx       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_r         <= '0;
      out_c         <= '0;
      out_eol       <= 1'b0;
      out_eom       <= 1'b0;
      out_last      <= 1'b0;
      out_mat_idx   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd_bad) begin
              state <= FINISH;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              rows          <= cmd_row;
              cols          <= cmd_col;
              all_mode      <= cmd_all;
              streamed_any  <= 1'b0;
              req_scale_row <= cmd_row;
              req_scale_col <= cmd_col;
              req_idx       <= cmd_all ? '0 : cmd_idx;
              busy          <= 1'b1;
              state         <= LOOKUP;
            end
          end
        end
        LOOKUP: state <= LOAD;
        LOAD: begin
          if (matrix_valid) begin
            streamed_any <= 1'b1;
            out_valid    <= 1'b1;
            out_data     <= matrix_data_flat[DATA_WIDTH-1:0];
            out_r        <= '0;
            out_c        <= '0;
            out_eol      <= load_eol;
            out_eom      <= load_eom;
            out_last     <= load_last;
            out_mat_idx  <= req_idx;
            state        <= STREAM;
          end else begin
            // In all mode a missing later index is the normal terminator.
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= !all_mode || !streamed_any;
            state <= FINISH;
          end
        end
        STREAM: begin
          if (hs) begin
            if (at_eom) begin
              out_valid <= 1'b0;
              out_eol   <= 1'b0;
              out_eom   <= 1'b0;
              out_last  <= 1'b0;
              if (!all_mode || last_idx_hit) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                state <= NEXT;
              end
            end else begin
              out_r    <= nxt_r;
              out_c    <= nxt_c;
              out_data <= buffer[slot_of(nxt_r, nxt_c)];
              out_eol  <= nxt_eol;
              out_eom  <= nxt_eom;
              out_last <= nxt_last;
            end
          end
        end
        NEXT: begin
          req_idx <= req_idx + SEL_IDX_W'(1);
          state   <= LOOKUP;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_stream_reader.md
Name: matrix_stream_reader

Overview:
- Read-side sequencer for the multi-matrix store.
- Accepts a command (scale rows x cols, local index, or "all matrices of this scale"), drives the store's combinational query port, and snapshots the selected matrix into a local buffer.
- Streams the elements row-major over a valid/ready interface to the display/UART output path.
- Also flags row ends, matrix ends and command completion.

Parameters:
- DATA_WIDTH, 8, element width.
- MAX_SIZE, 5, maximum rows/cols; store slot of element (r,c) is r*MAX_SIZE+c.
- MAX_MATRIX_PER_SIZE, 4, matrices per scale in the store.
- SEL_IDX_W, 2, local index width (matches store).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  command strobe, sampled only in IDLE
- cmd_row  in  3  requested rows (valid 1..MAX_SIZE)
- cmd_col  in  3  requested cols (valid 1..MAX_SIZE)
- cmd_idx  in  SEL_IDX_W  local index (ignored when cmd_all=1)
- cmd_all  in  1  1 = stream every stored matrix of this scale, idx 0 upward
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done when nothing was streamed
- req_scale_row  out  3  to store query port, registered
- req_scale_col  out  3  to store query port, registered
- req_idx  out  SEL_IDX_W  to store query port, registered
- matrix_valid  in  1  from store: requested entry exists
- matrix_data_flat  in  MAX_SIZE*MAX_SIZE*DATA_WIDTH  from store; slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  stream element valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  element value
- out_r  out  3  row of current element (0-based)
- out_c  out  3  column of current element (0-based)
- out_eol  out  1  current element is last of its row
- out_eom  out  1  current element is last of its matrix
- out_last  out  1  current element is final of the whole command
- out_mat_idx  out  SEL_IDX_W  local index of the matrix being streamed

Behaviour:
- Reset: state IDLE. All outputs 0, including req_* and out_* fields. The local buffer contents are don't-care. Reset mid-stream aborts immediately: no done pulse and no partial completion.
- States: IDLE, LOOKUP, LOAD, STREAM, NEXT, FINISH.
- IDLE, start=1:
  - If cmd_row or cmd_col is 0 or greater than MAX_SIZE, go to FINISH with an error; the store is never queried.
  - Otherwise latch rows/cols/all. Load req_scale_row/col with the command values. Load req_idx with cmd_idx (single) or 0 (all). busy=1 next cycle. Go to LOOKUP.
- start while busy is ignored and does not queue.
- LOOKUP: one settling cycle for the store's combinational read on the registered req_*. Go to LOAD.
- LOAD: sample matrix_valid.
  - 1: copy matrix_data_flat into the local buffer, set r=c=0, out_mat_idx=req_idx, go to STREAM. Later writes into the store do not affect the matrix being streamed.
  - 0: single mode goes to FINISH with err. All mode goes to FINISH with err only if no matrix has been streamed yet for this command; otherwise it finishes normally.
- STREAM:
  - out_valid=1. out_data = buffer[r*MAX_SIZE+c].
  - out_eol = (c==cols-1). out_eom = out_eol & (r==rows-1).
  - out_last = out_eom & (single mode, or req_idx==MAX_MATRIX_PER_SIZE-1).
  - While out_valid & !out_ready, every out_* field holds stable.
  - On handshake, advance c, then wrap c to 0 and increment r.
  - After the handshake on the out_eom element: single mode goes to FINISH. All mode goes to NEXT, or to FINISH if req_idx==MAX_MATRIX_PER_SIZE-1 (no index wrap-around).
  - out_valid drops the cycle after the final handshake of a matrix.
- NEXT: req_idx += 1, go to LOOKUP. This gives at least 3 idle stream cycles between matrices.
- All mode, early end: if a later index has matrix_valid=0, no element is ever flagged out_last. The consumer uses done as the terminator. err=0 in this case.
- FINISH: done=1 for one cycle, err as determined above, busy=0 in the same cycle. Return to IDLE; a new start is accepted in the following cycle.
- Latency:
  - Accepted start to first out_valid: 3 cycles.
  - Final handshake to done: 1 cycle.
  - Invalid-scale start to done/err: 1 cycle.
- Zero throughput loss inside a matrix: with out_ready held at 1, one element per cycle, rows*cols cycles per matrix.

Test Plan:
- Store has 2x3 matrix idx0 = {1,2,3,4,5,6} (slots 0,1,2,5,6,7); start single (2,3,0), out_ready=1 -> first out_valid 3 cycles after start. Data 1..6 on consecutive cycles; out_eol on 3 and 6; out_eom+out_last on 6; done one cycle later; err=0.
- Same command with out_ready toggling 1,0,0,1,... -> each element held stable during stalls; sequence and flags are identical to the previous case.
- Three 1x1 matrices {7},{8},{9} at idx0..2, start cmd_all (1,1) -> stream 7,8,9 with out_mat_idx 0,1,2 and out_eom on each; no out_last; done after idx3 lookup returns invalid; err=0.
- start single (4,4,2) where idx2 is absent -> no out_valid; done+err pulse 3 cycles after start. Separately, start (0,3) or (6,1) -> done+err next cycle; req_* never change.
- 5x5 stream under way, assert rst at element 10 -> next cycle all outputs 0, no done. A start after reset streams the full matrix from element 0.
- Store writer overwrites the streamed matrix at the 2nd STREAM cycle -> the rest of the output still equals the original snapshot. start pulsed mid-stream is ignored.
